// File: rtl/dmem_bus_bridge.sv
// Data-side bridge: held MEM-stage request -> single valid/ready bus transaction, one-entry posted write buffer, timeout abort.
// Latency: read ack 3 cycles after request, posted write ack 1 cycle; bus stalls hold the controller via withheld cpu_ack.
module dmem_bus_bridge #(
   parameter bit POSTED_WRITES  = 1'b1,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_WIDTH       = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_re,
   input  logic [3:0]  cpu_we,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_write,
   output logic [29:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic        bus_err,
   output logic        wbuf_busy
);

   typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;

   localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

   state_t              state, state_nxt;
   logic [TO_WIDTH-1:0] to_cnt;
   logic                wbuf_full;
   logic [29:0]         wbuf_addr;
   logic [31:0]         wbuf_data;
   logic [3:0]          wbuf_be;
   logic [29:0]         rd_addr;
   logic                ack_q;
   logic                err_q;
   logic [31:0]         rdata_q;

   logic wr_req, rd_req, timed_out, post_cap, np_cap;
   logic wb_clr, ack_nxt, err_nxt, rd_done, rd_abort, rd_latch;
   logic addr_lsb_unused;

   assign addr_lsb_unused = ^cpu_addr[1:0];

   // The controller keeps its request up during the ack cycle, so that cycle never samples it.
   assign wr_req    = (cpu_we != 4'b0000) && !ack_q;
   assign rd_req    = cpu_re && (cpu_we == 4'b0000) && !ack_q;
   assign timed_out = (state != IDLE) && (to_cnt == TO_LIMIT);
   assign post_cap  = POSTED_WRITES && wr_req && !wbuf_full;

   always_comb begin
      state_nxt = state;
      np_cap    = 1'b0;
      wb_clr    = 1'b0;
      ack_nxt   = 1'b0;
      err_nxt   = 1'b0;
      rd_done   = 1'b0;
      rd_abort  = 1'b0;
      rd_latch  = 1'b0;
      bus_valid = 1'b0;
      bus_write = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      bus_be    = '0;

      case (state)
         IDLE: begin
            if (wbuf_full) begin
               state_nxt = WR_ISSUE;
            end else if (rd_req) begin
               rd_latch  = 1'b1;
               state_nxt = RD_ISSUE;
            end else if (wr_req && !POSTED_WRITES) begin
               np_cap    = 1'b1;
               state_nxt = WR_ISSUE;
            end
         end

         WR_ISSUE: begin
            if (timed_out) begin
               // Posted data is dropped; a non-posted writer still gets its ack so it cannot hang.
               wb_clr    = 1'b1;
               err_nxt   = 1'b1;
               ack_nxt   = !POSTED_WRITES;
               state_nxt = IDLE;
            end else begin
               bus_valid = 1'b1;
               bus_write = 1'b1;
               bus_addr  = wbuf_addr;
               bus_wdata = wbuf_data;
               bus_be    = wbuf_be;
               if (bus_ready) begin
                  wb_clr    = 1'b1;
                  ack_nxt   = !POSTED_WRITES;
                  state_nxt = IDLE;
               end
            end
         end

         RD_ISSUE: begin
            if (timed_out) begin
               rd_abort  = 1'b1;
               err_nxt   = 1'b1;
               ack_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               bus_valid = 1'b1;
               bus_addr  = rd_addr;
               bus_be    = 4'b1111;
               if (bus_ready) begin
                  state_nxt = RD_WAIT;
               end
            end
         end

         RD_WAIT: begin
            if (timed_out) begin
               rd_abort  = 1'b1;
               err_nxt   = 1'b1;
               ack_nxt   = 1'b1;
               state_nxt = IDLE;
            end else if (bus_rvalid) begin
               rd_done   = 1'b1;
               ack_nxt   = 1'b1;
               state_nxt = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase

      if (post_cap) begin
         ack_nxt = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         to_cnt    <= '0;
         wbuf_full <= 1'b0;
         wbuf_addr <= '0;
         wbuf_data <= '0;
         wbuf_be   <= '0;
         rd_addr   <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state <= state_nxt;
         ack_q <= ack_nxt;
         err_q <= err_nxt;

         // Saturating: once at the limit it stays there until the state changes.
         if (state_nxt != state) begin
            to_cnt <= '0;
         end else if ((state != IDLE) && (to_cnt != TO_LIMIT)) begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
         end

         if (post_cap || np_cap) begin
            wbuf_full <= 1'b1;
            wbuf_addr <= cpu_addr[31:2];
            wbuf_data <= cpu_wdata;
            wbuf_be   <= cpu_we;
         end else if (wb_clr) begin
            wbuf_full <= 1'b0;
         end

         if (rd_latch) begin
            rd_addr <= cpu_addr[31:2];
         end

         if (rd_done) begin
            rdata_q <= bus_rdata;
         end else if (rd_abort) begin
            rdata_q <= '0;
         end
      end
   end

   assign cpu_ack   = ack_q;
   assign cpu_rdata = rdata_q;
   assign bus_err   = err_q;
   assign wbuf_busy = wbuf_full;

endmodule
